// File: rtl/mmio_sim_finisher.sv
`default_nettype none
// ============================================================================
// Module      : mmio_sim_finisher
// Description : Memory-mapped simulation terminator and console sink.
//               Sits on the data-memory bus next to RAM. Console bytes are
//               queued in a FIFO and streamed out to a bench sink; a TOHOST
//               write with bit 0 set waits for the FIFO to drain, then
//               raises finish_valid with finish_code = tohost >> 1.
// Ports       : clk, reset (async, active-high)
//               req_valid/req_ready/req_addr/req_wen/req_wdata - request
//               resp_valid/resp_error/resp_rdata               - response
//               out_valid/out_ready/out_data                   - console bytes
//               finish_valid/finish_code                       - end request
// Register map: +0x0 TOHOST (W), +0x4 CONSOLE (W), +0x8 STATUS (R)
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_sim_finisher #(
    parameter int                XLEN       = 32,
    parameter logic [XLEN-1:0]   BASE_ADDR  = 32'h1000_0000,
    parameter int                FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic              req_wen,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic              resp_error,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              finish_valid,
    output logic [XLEN-2:0]   finish_code
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;

    // Last byte of the window computed one bit wider so overflow is visible.
    localparam logic [XLEN:0]   c_LAST_WIDE    = {1'b0, BASE_ADDR} + (XLEN+1)'(11);
    localparam logic [XLEN-1:0] c_ADDR_LAST    = c_LAST_WIDE[XLEN-1:0];
    localparam logic [XLEN-1:0] c_ADDR_TOHOST  = BASE_ADDR;
    localparam logic [XLEN-1:0] c_ADDR_CONSOLE = BASE_ADDR + XLEN'(4);
    localparam logic [XLEN-1:0] c_ADDR_STATUS  = BASE_ADDR + XLEN'(8);
    localparam logic [c_CW-1:0] c_CNT_FULL     = c_CW'(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE      = c_CW'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE      = c_PW'(1);

    if (c_LAST_WIDE[XLEN]) begin : g_chk_base
        $error("mmio_sim_finisher: BASE_ADDR+0xB overflows XLEN");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("mmio_sim_finisher: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic              r_resp_valid;
    logic              r_resp_error;
    logic [XLEN-1:0]   r_resp_rdata;
    logic [XLEN-2:0]   r_finish_code;

    logic              w_in_range;
    logic              w_err;
    logic              w_tohost_wr;
    logic              w_console_wr;
    logic              w_status_rd;
    logic              w_empty;
    logic              w_full;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_finish_trig;
    logic [XLEN-1:0]   w_status;

    // ---------------------------------------------------------------- decode
    assign w_in_range   = (req_addr >= BASE_ADDR) && (req_addr <= c_ADDR_LAST);
    assign w_err        = !(w_in_range && (req_addr[1:0] == 2'b00));
    assign w_tohost_wr  = req_wen  && !w_err && (req_addr == c_ADDR_TOHOST);
    assign w_console_wr = req_wen  && !w_err && (req_addr == c_ADDR_CONSOLE);
    assign w_status_rd  = !req_wen && !w_err && (req_addr == c_ADDR_STATUS);

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_CNT_FULL);
    assign w_accept = req_valid && req_ready;
    // A full FIFO deasserts req_ready, so an accepted push never meets a full FIFO.
    assign w_push   = w_accept && w_console_wr;
    assign w_pop    = !w_empty && out_ready;

    // TOHOST writes are never stalled in RUN, so req_ready is implied here;
    // keeping req_ready out of this term avoids a combinational loop with the FSM.
    assign w_finish_trig = (r_state == ST_RUN) && req_valid && w_tohost_wr && req_wdata[0];

    always_comb begin
        w_status              = '0;
        w_status[c_CW-1:0]    = r_count;
        w_status[XLEN-1]      = (r_state != ST_RUN);
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        finish_valid = 1'b0;
        case (r_state)
            ST_RUN: begin
                req_ready = !(w_console_wr && w_full);
                if (w_finish_trig) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                finish_valid = 1'b1;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; out_data is masked while empty instead.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= req_wdata[7:0];
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];

    // ------------------------------------------------------------ response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= w_accept;
            r_resp_error <= w_accept && w_err;
            r_resp_rdata <= (w_accept && w_status_rd) ? w_status : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_finish_code <= '0;
        end else if (w_finish_trig) begin
            r_finish_code <= req_wdata[XLEN-1:1];
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_error  = r_resp_error;
    assign resp_rdata  = r_resp_rdata;
    assign finish_code = r_finish_code;

endmodule
`default_nettype wire

// File: tb/tb_mmio_sim_finisher.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_sim_finisher
// Description : Directed self-checking bench for mmio_sim_finisher.
//               Inputs change 1 time unit after the rising edge; outputs are
//               sampled 1 or 2 units after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_sim_finisher;

    localparam int          XLEN      = 32;
    localparam logic [31:0] c_BASE    = 32'h1000_0000;
    localparam logic [31:0] c_TOHOST  = c_BASE;
    localparam logic [31:0] c_CONSOLE = c_BASE + 32'h4;
    localparam logic [31:0] c_STATUS  = c_BASE + 32'h8;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [XLEN-1:0]   req_addr;
    logic              req_wen;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_error;
    logic [XLEN-1:0]   resp_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              finish_valid;
    logic [XLEN-2:0]   finish_code;

    int errors = 0;
    int checks = 0;

    logic        e;
    logic [31:0] r;
    int          n;
    int          k;
    int          acc_cycle;
    logic        acc;

    mmio_sim_finisher #(
        .XLEN       (XLEN),
        .BASE_ADDR  (c_BASE),
        .FIFO_DEPTH (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wen      (req_wen),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_error   (resp_error),
        .resp_rdata   (resp_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .finish_valid (finish_valid),
        .finish_code  (finish_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Entered and left 1 unit after a rising edge. On return the response
    // of the accepted request is on the bus.
    task automatic xfer(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                        output logic err, output logic [31:0] rdata);
        logic ok;
        ok        = 1'b0;
        req_addr  = addr;
        req_wen   = wen;
        req_wdata = wdata;
        req_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            ok = req_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        req_valid = 1'b0;
        chk("accepted", ok, 1'b1);
        chk("resp_valid", resp_valid, 1'b1);
        err   = resp_error;
        rdata = resp_rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wen   = 1'b0;
        req_wdata = '0;
        out_ready = 1'b0;
        #2;
        chk("rst req_ready",    req_ready,    1'b1);
        chk("rst resp_valid",   resp_valid,   1'b0);
        chk("rst resp_error",   resp_error,   1'b0);
        chk("rst resp_rdata",   resp_rdata,   32'h0);
        chk("rst out_valid",    out_valid,    1'b0);
        chk("rst out_data",     out_data,     8'h00);
        chk("rst finish_valid", finish_valid, 1'b0);
        chk("rst finish_code",  finish_code,  31'h0);
        cycle();
        reset = 1'b0;

        // Two console bytes with the sink always ready.
        out_ready = 1'b1;
        xfer(c_CONSOLE, 1'b1, 32'h48, e, r);
        chk("con1 err", e, 1'b0);
        chk("con1 out_valid", out_valid, 1'b1);
        chk("con1 out_data", out_data, 8'h48);
        xfer(c_CONSOLE, 1'b1, 32'h69, e, r);
        chk("con2 err", e, 1'b0);
        chk("con2 out_data", out_data, 8'h69);
        cycle();
        chk("resp pulse ends", resp_valid, 1'b0);
        chk("con drained", out_valid, 1'b0);

        // Fill to depth, stall the 17th, release the sink and follow order.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            xfer(c_CONSOLE, 1'b1, 32'h10 + i, e, r);
        end
        req_addr  = c_CONSOLE;
        req_wen   = 1'b1;
        req_wdata = 32'h20;
        req_valid = 1'b1;
        #1;
        chk("full stall", req_ready, 1'b0);
        out_ready = 1'b1;
        k         = 0;
        acc_cycle = -1;
        for (int c = 0; c < 40 && k < 17; c++) begin
            if (out_valid) begin
                chk("fifo order", out_data, 8'h10 + k);
                k++;
            end
            acc = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                req_valid = 1'b0;
                acc_cycle = c;
            end
            #1;
        end
        chk("fifo byte count", k, 17);
        chk("17th accept cycle", acc_cycle, 1);
        chk("fifo empty after wrap", out_valid, 1'b0);
        cycle();

        // STATUS and decode errors with five bytes held.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            xfer(c_CONSOLE, 1'b1, 32'hA0 + i, e, r);
        end
        xfer(c_STATUS, 1'b0, 32'h0, e, r);
        chk("status err", e, 1'b0);
        chk("status count5", r, 32'h5);
        xfer(c_BASE + 32'h10, 1'b0, 32'h0, e, r);
        chk("oor err", e, 1'b1);
        chk("oor rdata", r, 32'h0);
        xfer(c_BASE + 32'h5, 1'b1, 32'hFF, e, r);
        chk("misaligned err", e, 1'b1);
        xfer(c_STATUS, 1'b1, 32'hFFFF_FFFF, e, r);
        chk("status write err", e, 1'b0);
        xfer(c_STATUS, 1'b0, 32'h0, e, r);
        chk("status unchanged", r, 32'h5);
        xfer(c_TOHOST, 1'b0, 32'h0, e, r);
        chk("tohost read err", e, 1'b0);
        chk("tohost read rdata", r, 32'h0);
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 20) begin
            cycle();
            n++;
        end
        chk("drain five", out_valid, 1'b0);

        // Finish waits for three queued bytes to drain.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            xfer(c_CONSOLE, 1'b1, 32'h30 + i, e, r);
        end
        xfer(c_TOHOST, 1'b1, 32'h1, e, r);
        chk("tohost1 err", e, 1'b0);
        cycle();
        cycle();
        #1;
        chk("drain req_ready", req_ready, 1'b0);
        chk("drain no finish", finish_valid, 1'b0);
        chk("drain bytes held", out_valid, 1'b1);
        out_ready = 1'b1;
        n = 0;
        while (!finish_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("finish latency", n, 4);
        chk("finish_valid", finish_valid, 1'b1);
        chk("finish_code 0", finish_code, 31'h0);
        chk("done req_ready", req_ready, 1'b0);
        chk("done empty", out_valid, 1'b0);

        // Finish with an empty FIFO: two cycles after acceptance.
        do_reset();
        xfer(c_TOHOST, 1'b1, 32'h55, e, r);
        chk("quick drain state", finish_valid, 1'b0);
        cycle();
        chk("quick finish", finish_valid, 1'b1);
        chk("quick code", finish_code, 31'h2A);

        // Asynchronous reset in DRAIN with four bytes queued.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            xfer(c_CONSOLE, 1'b1, 32'h40 + i, e, r);
        end
        xfer(c_TOHOST, 1'b1, 32'h7, e, r);
        #1;
        chk("pre-reset code", finish_code, 31'h3);
        chk("pre-reset ready", req_ready, 1'b0);
        reset = 1'b1;
        #1;
        chk("async req_ready",  req_ready,    1'b1);
        chk("async resp_valid", resp_valid,   1'b0);
        chk("async out_valid",  out_valid,    1'b0);
        chk("async out_data",   out_data,     8'h00);
        chk("async finish",     finish_valid, 1'b0);
        chk("async code",       finish_code,  31'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        xfer(c_STATUS, 1'b0, 32'h0, e, r);
        chk("post-reset status", r, 32'h0);
        chk("post-reset err", e, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_sim_finisher.md
Name: mmio_sim_finisher

Overview:
- Memory-mapped responder for simulation-only termination and console output. It sits on the data-memory bus beside the RAM.
- The CPU core, acting as initiator, writes the tohost and console registers.
- The block buffers console bytes in a FIFO, drains them to a testbench sink, and raises a finish request once output has drained. The testbench performs $fflush/$finish on that request.

Parameters:
- XLEN, 32, data/address width (matches UIntX/Addr).
- BASE_ADDR, 32'h1000_0000, first byte of the register window.
- FIFO_DEPTH, 16, console FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts request this cycle
- req_addr  in  XLEN  byte address
- req_wen  in  1  1 = write, 0 = read
- req_wdata  in  XLEN  write data
- resp_valid  out  1  response pulse, exactly one per accepted request
- resp_error  out  1  access fault; valid with resp_valid
- resp_rdata  out  XLEN  read data; valid with resp_valid
- out_valid  out  1  console byte available
- out_ready  in  1  sink takes the byte
- out_data  out  8  console byte
- finish_valid  out  1  level; simulation end requested
- finish_code  out  XLEN-1  exit code (tohost >> 1)

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, out_valid=0, out_data=0, finish_valid=0, finish_code=0. FIFO empty, state RUN.
  - Reset asserted mid-operation clears everything immediately, including pending bytes.
- Register map (offset from BASE_ADDR):
  - 0x0 TOHOST (W).
  - 0x4 CONSOLE (W; byte = wdata[7:0]).
  - 0x8 STATUS (R; rdata = {FIFO count zero-extended}, bit31 = finishing).
  - Reads of 0x0/0x4 return 0 without error. Writes to 0x8 are ignored without error.
- Decode:
  - In range when BASE_ADDR <= addr <= BASE_ADDR+0xB, same inclusive semantics as x_in_range.
  - Out of range, or addr[1:0] != 0 → resp_error=1, rdata=0, no side effect.
- Handshake:
  - A request is accepted on a cycle with req_valid && req_ready.
  - resp_valid goes high exactly one cycle later for one cycle, with error/rdata registered.
  - Back-to-back accepted requests give back-to-back responses.
  - req_ready is combinational: 1 in RUN, except when the request is a CONSOLE write and the FIFO is full. In that case req_ready=0 and the initiator stalls.
  - req_ready is 0 in DRAIN and DONE.
- FIFO:
  - Circular buffer with wrap-around pointers and a count of width clog2(FIFO_DEPTH)+1.
  - Push on an accepted CONSOLE write. Pop when out_valid && out_ready.
  - Push and pop in the same cycle with the FIFO full: only the pop happens; req_ready was already 0.
  - Push and pop in the same cycle when not full: count is unchanged.
  - out_valid = !empty; out_data = head entry (registered storage).
- State machine:
  - RUN: accepted TOHOST write with wdata[0]=1 → finish_code <= wdata[XLEN-1:1], go to DRAIN. TOHOST write with wdata[0]=0 is accepted with no effect.
  - DRAIN: no new requests; the response for the triggering write is still issued. When the FIFO is empty → DONE.
  - DONE: finish_valid=1, held until reset. FIFO stays empty; req_ready=0.
  - TOHOST write that arrives while the FIFO is already empty: DRAIN lasts one cycle, so finish_valid rises 2 cycles after acceptance.
- Arithmetic: address comparison is unsigned XLEN. BASE_ADDR+0xB must not overflow; this is an elaboration-time check.

Test Plan:
- CONSOLE writes of 0x48, 0x69 with out_ready=1 → resp_valid 1 cycle after each, resp_error=0; out_data 0x48 then 0x69; FIFO empties.
- out_ready=0, 17 CONSOLE writes (depth 16) → 16 accepted, then req_ready=0 on the 17th. Raise out_ready → 17th accepted the cycle after the first pop; byte order preserved across pointer wrap.
- 3 bytes queued with out_ready=0, then TOHOST write 0x0000_0001 → req_ready=0 afterwards, finish_valid stays 0. Drain 3 bytes → finish_valid=1, finish_code=0.
- TOHOST write 0x0000_0055 with the FIFO empty → finish_valid=1 two cycles after acceptance, finish_code=0x2A.
- Read STATUS with 5 bytes queued → rdata=5. Read BASE+0x10 → resp_error=1. Write BASE+0x5 → resp_error=1 and nothing pushed.
- Assert reset during DRAIN with 4 bytes queued → all outputs at reset values immediately, count=0, req_ready=1 after release.
